// File: rtl/my_soc_pkg.sv
// my_soc_pkg: shared types and constants for the my_soc debug SoC.
//   - tap_state_e  : IEEE 1149.1 TAP controller states
//   - IR_*         : JTAG instruction opcodes
//   - uart_state_e : UART TX/RX frame states
//   - tap_next()   : TAP next-state function (TMS-driven)
package my_soc_pkg;

    typedef enum logic [3:0] {
        TapReset,
        TapIdle,
        TapSelectDr,
        TapCaptureDr,
        TapShiftDr,
        TapExit1Dr,
        TapPauseDr,
        TapExit2Dr,
        TapUpdateDr,
        TapSelectIr,
        TapCaptureIr,
        TapShiftIr,
        TapExit1Ir,
        TapPauseIr,
        TapExit2Ir,
        TapUpdateIr
    } tap_state_e;

    localparam logic [3:0] IR_IDCODE = 4'b0001;
    localparam logic [3:0] IR_UART   = 4'b0010;
    localparam logic [3:0] IR_BYPASS = 4'b1111;

    typedef enum logic [1:0] {
        UartIdle,
        UartStart,
        UartData,
        UartStop
    } uart_state_e;

    function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
        tap_state_e nxt;
        nxt = TapReset;
        unique case (s)
            TapReset:     nxt = tms ? TapReset    : TapIdle;
            TapIdle:      nxt = tms ? TapSelectDr : TapIdle;
            TapSelectDr:  nxt = tms ? TapSelectIr : TapCaptureDr;
            TapCaptureDr: nxt = tms ? TapExit1Dr  : TapShiftDr;
            TapShiftDr:   nxt = tms ? TapExit1Dr  : TapShiftDr;
            TapExit1Dr:   nxt = tms ? TapUpdateDr : TapPauseDr;
            TapPauseDr:   nxt = tms ? TapExit2Dr  : TapPauseDr;
            TapExit2Dr:   nxt = tms ? TapUpdateDr : TapShiftDr;
            TapUpdateDr:  nxt = tms ? TapSelectDr : TapIdle;
            TapSelectIr:  nxt = tms ? TapReset    : TapCaptureIr;
            TapCaptureIr: nxt = tms ? TapExit1Ir  : TapShiftIr;
            TapShiftIr:   nxt = tms ? TapExit1Ir  : TapShiftIr;
            TapExit1Ir:   nxt = tms ? TapUpdateIr : TapPauseIr;
            TapPauseIr:   nxt = tms ? TapExit2Ir  : TapPauseIr;
            TapExit2Ir:   nxt = tms ? TapUpdateIr : TapShiftIr;
            TapUpdateIr:  nxt = tms ? TapSelectDr : TapIdle;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/my_soc_uart.sv
// my_soc_uart: 8N1 UART transmitter and receiver with per-bit baud counters.
// Ports:
//   clk, reset_n        - system clock, synchronous active-high reset
//   tx_start, tx_data   - one-cycle request to send tx_data (ignored while busy)
//   tx_busy             - high from the request until the stop bit completes
//   tx                  - registered serial output, idle high
//   rx                  - already-synchronized serial input
//   rx_clear            - clears rx_valid (a completing byte wins)
//   rx_byte, rx_valid   - last good byte and its unread flag
module my_soc_uart
    import my_soc_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       tx,
    input  logic       rx,
    input  logic       rx_clear,
    output logic [7:0] rx_byte,
    output logic       rx_valid
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

    uart_state_e   tx_state_q;
    logic [CW-1:0] tx_cnt_q;
    logic [2:0]    tx_idx_q;
    logic [7:0]    tx_shift_q;

    uart_state_e   rx_state_q;
    logic [CW-1:0] rx_cnt_q;
    logic [2:0]    rx_idx_q;
    logic [7:0]    rx_shift_q;
    logic          rx_prev_q;

    assign tx_busy = (tx_state_q != UartIdle);

    always_ff @(posedge clk) begin
        if (reset_n) begin
            tx_state_q <= UartIdle;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_shift_q <= '0;
            tx         <= 1'b1;
        end else begin
            unique case (tx_state_q)
                UartIdle: begin
                    if (tx_start) begin
                        tx_state_q <= UartStart;
                        tx_shift_q <= tx_data;
                        tx_cnt_q   <= '0;
                        tx         <= 1'b0;
                    end
                end
                UartStart: begin
                    if (tx_cnt_q == BIT_END) begin
                        tx_cnt_q   <= '0;
                        tx_idx_q   <= '0;
                        tx_state_q <= UartData;
                        tx         <= tx_shift_q[0];
                        tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                UartData: begin
                    if (tx_cnt_q == BIT_END) begin
                        tx_cnt_q <= '0;
                        if (tx_idx_q == 3'd7) begin
                            tx_state_q <= UartStop;
                            tx         <= 1'b1;
                        end else begin
                            tx_idx_q   <= tx_idx_q + 1'b1;
                            tx         <= tx_shift_q[0];
                            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                UartStop: begin
                    if (tx_cnt_q == BIT_END) begin
                        tx_cnt_q   <= '0;
                        tx_state_q <= UartIdle;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                default: tx_state_q <= UartIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            rx_state_q <= UartIdle;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_shift_q <= '0;
            rx_prev_q  <= 1'b1;
            rx_byte    <= '0;
            rx_valid   <= 1'b0;
        end else begin
            rx_prev_q <= rx;
            // Placed before the FSM so a byte completing this cycle re-sets it.
            if (rx_clear) begin
                rx_valid <= 1'b0;
            end
            unique case (rx_state_q)
                UartIdle: begin
                    if (rx_prev_q && !rx) begin
                        rx_state_q <= UartStart;
                        rx_cnt_q   <= '0;
                    end
                end
                UartStart: begin
                    // Mid-start re-check rejects glitches shorter than half a bit.
                    if (rx_cnt_q == HALF_END) begin
                        rx_cnt_q   <= '0;
                        rx_idx_q   <= '0;
                        rx_state_q <= rx ? UartIdle : UartData;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                UartData: begin
                    if (rx_cnt_q == BIT_END) begin
                        rx_cnt_q   <= '0;
                        rx_shift_q <= {rx, rx_shift_q[7:1]};
                        if (rx_idx_q == 3'd7) begin
                            rx_state_q <= UartStop;
                        end else begin
                            rx_idx_q <= rx_idx_q + 1'b1;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                UartStop: begin
                    if (rx_cnt_q == BIT_END) begin
                        rx_cnt_q   <= '0;
                        rx_state_q <= UartIdle;
                        // A low stop bit is a framing error: drop the byte.
                        if (rx) begin
                            rx_byte  <= rx_shift_q;
                            rx_valid <= 1'b1;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                default: rx_state_q <= UartIdle;
            endcase
        end
    end

endmodule

// File: rtl/my_soc.sv
// my_soc: chip top. An oversampled JTAG TAP gives a host access to an 8N1 UART.
// Ports:
//   clk      - system clock (only clock)
//   reset_n  - synchronous, active-high reset (1 = reset)
//   uart_tx  - UART transmit, idle high
//   uart_rx  - UART receive, asynchronous
//   TCK, TMS, TDI - JTAG inputs, sampled as data by clk
//   TDO      - JTAG data out, changes after a detected TCK fall
// Build option: MY_SOC_LOOPBACK_EN feeds the receiver from the transmitter and
// ignores the uart_rx pin.
module my_soc
    import my_soc_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter logic [31:0] IDCODE       = 32'h1000_0001
) (
    input  logic clk,
    input  logic reset_n,
    output logic uart_tx,
    input  logic uart_rx,
    input  logic TCK,
    input  logic TMS,
    input  logic TDI,
    output logic TDO
);

    logic       rx_pin;
    logic [1:0] tck_sync_q, tms_sync_q, tdi_sync_q, rx_sync_q;
    logic       tck_prev_q;
    logic       tck_rise, tck_fall, tms_s, tdi_s;

    tap_state_e tap_state_q, tap_next_state;
    logic [3:0]  ir_q, ir_sr_q;
    logic [31:0] dr_q, dr_capture, dr_shifted;
    logic        tdo_q;

    logic       tx_start, tx_busy, rx_clear, rx_valid;
    logic [7:0] rx_byte;

`ifdef MY_SOC_LOOPBACK_EN
    assign rx_pin = uart_tx;
`else
    assign rx_pin = uart_rx;
`endif

    always_ff @(posedge clk) begin
        if (reset_n) begin
            tck_sync_q <= '0;
            tms_sync_q <= '0;
            tdi_sync_q <= '0;
            rx_sync_q  <= 2'b11;
            tck_prev_q <= 1'b0;
        end else begin
            tck_sync_q <= {tck_sync_q[0], TCK};
            tms_sync_q <= {tms_sync_q[0], TMS};
            tdi_sync_q <= {tdi_sync_q[0], TDI};
            rx_sync_q  <= {rx_sync_q[0], rx_pin};
            tck_prev_q <= tck_sync_q[1];
        end
    end

    assign tck_rise = tck_sync_q[1] & ~tck_prev_q;
    assign tck_fall = ~tck_sync_q[1] & tck_prev_q;
    assign tms_s    = tms_sync_q[1];
    assign tdi_s    = tdi_sync_q[1];

    assign tap_next_state = tap_next(tap_state_q, tms_s);

    // DR length follows the current instruction: 32 (IDCODE), 9 (UART), 1 (BYPASS).
    always_comb begin
        dr_capture = '0;
        dr_shifted = {31'b0, tdi_s};
        case (ir_q)
            IR_IDCODE: begin
                dr_capture = IDCODE;
                dr_shifted = {tdi_s, dr_q[31:1]};
            end
            IR_UART: begin
                dr_capture = {23'b0, rx_valid, rx_byte};
                dr_shifted = {23'b0, tdi_s, dr_q[8:1]};
            end
            default: ;
        endcase
    end

    assign rx_clear = tck_rise && (tap_state_q == TapCaptureDr) && (ir_q == IR_UART);
    assign tx_start = tck_rise && (tap_state_q == TapUpdateDr) && (ir_q == IR_UART)
                      && dr_q[8] && !tx_busy;

    always_ff @(posedge clk) begin
        if (reset_n) begin
            tap_state_q <= TapReset;
            ir_q        <= IR_IDCODE;
            ir_sr_q     <= '0;
            dr_q        <= '0;
            tdo_q       <= 1'b0;
        end else begin
            if (tck_rise) begin
                tap_state_q <= tap_next_state;
                case (tap_state_q)
                    TapCaptureIr: ir_sr_q <= 4'b0001;
                    TapShiftIr:   ir_sr_q <= {tdi_s, ir_sr_q[3:1]};
                    TapUpdateIr:  ir_q    <= ir_sr_q;
                    TapCaptureDr: dr_q    <= dr_capture;
                    TapShiftDr:   dr_q    <= dr_shifted;
                    default: ;
                endcase
                if (tap_next_state == TapReset) begin
                    ir_q <= IR_IDCODE;
                end
            end
            if (tck_fall) begin
                if (tap_state_q == TapShiftDr) begin
                    tdo_q <= dr_q[0];
                end else if (tap_state_q == TapShiftIr) begin
                    tdo_q <= ir_sr_q[0];
                end else begin
                    tdo_q <= 1'b0;
                end
            end
        end
    end

    assign TDO = tdo_q;

    my_soc_uart #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart (
        .clk      (clk),
        .reset_n  (reset_n),
        .tx_start (tx_start),
        .tx_data  (dr_q[7:0]),
        .tx_busy  (tx_busy),
        .tx       (uart_tx),
        .rx       (rx_sync_q[1]),
        .rx_clear (rx_clear),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid)
    );

endmodule

// File: tb/tb_my_soc.sv
// tb_my_soc: directed, self-checking bench for my_soc. Expected values are
// queued when stimulus is applied and popped when the DUT result is observed.
module tb_my_soc;

    localparam int unsigned CPB      = 868;
    localparam int          HALF_TCK = 8;
    localparam logic [31:0] IDCODE   = 32'h1000_0001;

    logic clk = 1'b0;
    logic reset_n, uart_tx, uart_rx, TCK, TMS, TDI, TDO;

    int vectors     = 0;
    int miscompares = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    my_soc #(
        .CLKS_PER_BIT(CPB),
        .IDCODE      (IDCODE)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .uart_tx (uart_tx),
        .uart_rx (uart_rx),
        .TCK     (TCK),
        .TMS     (TMS),
        .TDI     (TDI),
        .TDO     (TDO)
    );

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] exp_v;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $error("FAIL %s: observed %0h, no expected value queued", tag, obs);
        end else begin
            exp_v = exp_q.pop_front();
            assert (obs === exp_v) else begin
                miscompares++;
                $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
            end
        end
    endtask

    // One TCK period; tdo is sampled while TCK is low, before the rise.
    task automatic jtag_clk(input logic tms, input logic tdi, output logic tdo);
        tdo = TDO;
        TMS = tms;
        TDI = tdi;
        repeat (2) @(negedge clk);
        TCK = 1'b1;
        repeat (HALF_TCK) @(negedge clk);
        TCK = 1'b0;
        repeat (HALF_TCK) @(negedge clk);
    endtask

    task automatic jtag_shift(input int n, input logic [31:0] din, output logic [31:0] dout);
        logic b;
        dout = '0;
        for (int i = 0; i < n; i++) begin
            jtag_clk(i == n - 1, din[i], b);
            dout[i] = b;
        end
    endtask

    // Both scans start and end in Run-Test/Idle.
    task automatic scan_ir(input logic [3:0] ir, output logic [31:0] dout);
        logic b;
        jtag_clk(1'b1, 1'b0, b);
        jtag_clk(1'b1, 1'b0, b);
        jtag_clk(1'b0, 1'b0, b);
        jtag_clk(1'b0, 1'b0, b);
        jtag_shift(4, {28'b0, ir}, dout);
        jtag_clk(1'b1, 1'b0, b);
        jtag_clk(1'b0, 1'b0, b);
    endtask

    task automatic scan_dr(input int n, input logic [31:0] din, output logic [31:0] dout);
        logic b;
        jtag_clk(1'b1, 1'b0, b);
        jtag_clk(1'b0, 1'b0, b);
        jtag_clk(1'b0, 1'b0, b);
        jtag_shift(n, din, dout);
        jtag_clk(1'b1, 1'b0, b);
        jtag_clk(1'b0, 1'b0, b);
    endtask

    task automatic watch_tx_frame();
        int n = 0;
        int w = 0;
        while (uart_tx !== 1'b0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check("tx_start_seen", 32'(n < 4000));
        while (uart_tx === 1'b0 && w < 2 * CPB) begin
            @(negedge clk);
            w++;
        end
        check("tx_start_width", 32'(w));
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            if (i > 0) repeat (CPB) @(negedge clk);
            check($sformatf("tx_bit%0d", i), {31'b0, uart_tx});
        end
    endtask

    task automatic uart_send(input logic [7:0] d, input logic stop);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = d[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d, d2;
        logic        b;
        int          lows;

        TCK = 1'b0;
        TMS = 1'b1;
        TDI = 1'b0;
        uart_rx = 1'b1;
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        exp_q.push_back(32'd1);
        check("reset_uart_tx", {31'b0, uart_tx});
        exp_q.push_back(32'd0);
        check("reset_tdo", {31'b0, TDO});

        repeat (5) jtag_clk(1'b1, 1'b0, b);
        jtag_clk(1'b0, 1'b0, b);
        exp_q.push_back(IDCODE);
        scan_dr(32, 32'h0, d);
        check("idcode", d);

        exp_q.push_back(32'h1);
        scan_ir(4'hF, d);
        check("ir_capture_bypass", d);
        // One-bit DR: output is TDI delayed by one TCK, first bit is the captured 0.
        exp_q.push_back(32'h14A);
        scan_dr(9, 32'h0A5, d);
        check("bypass", d);

        exp_q.push_back(32'h1);
        scan_ir(4'h2, d);
        check("ir_capture_uart", d);

        // 0x55 LSB first: 1,0,1,0,1,0,1,0 then stop 1.
        exp_q.push_back(32'd1);
        exp_q.push_back(32'(CPB));
        for (int i = 0; i < 8; i++) exp_q.push_back(32'((i + 1) % 2));
        exp_q.push_back(32'd1);
        fork
            scan_dr(9, 32'h155, d2);
            watch_tx_frame();
        join
        repeat (CPB) @(negedge clk);

        uart_send(8'hA3, 1'b1);
        exp_q.push_back(32'h1A3);
        scan_dr(9, 32'h0, d);
        check("rx_capture_valid", d);
        exp_q.push_back(32'h0A3);
        scan_dr(9, 32'h0, d);
        check("rx_capture_cleared", d);

        uart_send(8'h5C, 1'b0);
        exp_q.push_back(32'h0A3);
        scan_dr(9, 32'h0, d);
        check("rx_framing_error", d);

        // Start a frame of 0x00, park the TAP in Shift-IR, then reset mid-frame.
        scan_dr(9, 32'h100, d);
        exp_q.push_back(32'd0);
        check("abort_tx_active", {31'b0, uart_tx});
        repeat (2 * CPB) @(negedge clk);
        jtag_clk(1'b1, 1'b0, b);
        jtag_clk(1'b1, 1'b0, b);
        jtag_clk(1'b0, 1'b0, b);
        jtag_clk(1'b0, 1'b0, b);
        reset_n = 1'b1;
        @(negedge clk);
        exp_q.push_back(32'd1);
        check("abort_uart_tx", {31'b0, uart_tx});
        exp_q.push_back(32'd0);
        check("abort_tdo", {31'b0, TDO});
        @(negedge clk);
        reset_n = 1'b0;
        lows = 0;
        repeat (10 * CPB) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) lows++;
        end
        exp_q.push_back(32'd0);
        check("abort_no_more_bits", 32'(lows));

        jtag_clk(1'b0, 1'b0, b);
        exp_q.push_back(IDCODE);
        scan_dr(32, 32'h0, d);
        check("idcode_after_reset", d);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
